// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX core among N_REQ byte sources.
// A granted requester keeps the core until it sends a byte flagged last.
module uart_tx_sched #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 2047,
   localparam int IW     = $clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   grant,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   input  logic               tx_done,
   output logic               busy,
   output logic [IW-1:0]      owner,
   output logic               locked,
   output logic               err_timeout,
   output logic [7:0]         err_count
);

   localparam int TW = 16;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic             tx_start_q, tx_start_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic             locked_q, locked_d;
   logic             err_timeout_q, err_timeout_d;
   logic [7:0]       err_count_q, err_count_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             last_q, last_d;

   logic             pick_vld;
   logic [IW-1:0]    pick_idx;
   logic [IW-1:0]    cand;
   logic             sel_vld;
   logic [IW-1:0]    sel_idx;

   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N_REQ) begin
         s = s - N_REQ;
      end
      return IW'(s);
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Round-robin scan starting at rr_ptr, first requester wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = wrap_add(rr_ptr_q, i);
         if (!pick_vld && req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   // While locked, only the owner may be served.
   always_comb begin
      sel_vld = locked_q ? req[owner_q] : pick_vld;
      sel_idx = locked_q ? owner_q : pick_idx;
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = '0;
      tx_start_d    = 1'b0;
      err_timeout_d = 1'b0;
      tx_data_d     = tx_data_q;
      owner_d       = owner_q;
      locked_d      = locked_q;
      err_count_d   = err_count_q;
      rr_ptr_d      = rr_ptr_q;
      timer_d       = timer_q;
      last_d        = last_q;

      case (state_q)
         S_IDLE: begin
            if (sel_vld) begin
               grant_d   = N_REQ'(1) << sel_idx;
               tx_data_d = req_data[{sel_idx, 3'b000} +: 8];
               last_d    = req_last[sel_idx];
               owner_d   = sel_idx;
               locked_d  = ~req_last[sel_idx];
               timer_d   = '0;
               state_d   = S_ISSUE;
            end else if (!locked_q) begin
               timer_d = '0;
            end else if (timer_q == TMAX) begin
               // Owner stalled mid-packet: release the lock and move on.
               locked_d      = 1'b0;
               rr_ptr_d      = wrap_add(owner_q, 1);
               err_timeout_d = 1'b1;
               err_count_d   = sat_inc8(err_count_q);
               timer_d       = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         S_ISSUE: begin
            tx_start_d = 1'b1;
            timer_d    = '0;
            state_d    = S_WAIT_DONE;
         end

         S_WAIT_DONE: begin
            if (tx_done) begin
               timer_d = '0;
               state_d = S_IDLE;
               if (last_q) begin
                  locked_d = 1'b0;
                  rr_ptr_d = wrap_add(owner_q, 1);
               end
            end else if (timer_q == TMAX) begin
               err_timeout_d = 1'b1;
               err_count_d   = sat_inc8(err_count_q);
               locked_d      = 1'b0;
               rr_ptr_d      = wrap_add(owner_q, 1);
               timer_d       = '0;
               state_d       = S_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         grant_q       <= '0;
         tx_start_q    <= 1'b0;
         tx_data_q     <= '0;
         owner_q       <= '0;
         locked_q      <= 1'b0;
         err_timeout_q <= 1'b0;
         err_count_q   <= '0;
         rr_ptr_q      <= '0;
         timer_q       <= '0;
         last_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         tx_start_q    <= tx_start_d;
         tx_data_q     <= tx_data_d;
         owner_q       <= owner_d;
         locked_q      <= locked_d;
         err_timeout_q <= err_timeout_d;
         err_count_q   <= err_count_d;
         rr_ptr_q      <= rr_ptr_d;
         timer_q       <= timer_d;
         last_q        <= last_d;
      end
   end

   assign grant       = grant_q;
   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign busy        = (state_q != S_IDLE);
   assign owner       = owner_q;
   assign locked      = locked_q;
   assign err_timeout = err_timeout_q;
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: table of byte transactions plus
// hand-written sequences for timeouts, owner stall and async reset.
module tb_uart_tx_sched;

   localparam int N  = 4;
   localparam int TO = 16;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  grant;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic        busy;
   logic [1:0]  owner;
   logic        locked;
   logic        err_timeout;
   logic [7:0]  err_count;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic [3:0]  last;
      int          dly;
      int          idx;
      logic [7:0]  byt;
      logic        lock_g;
      logic        lock_d;
   } vec_t;

   vec_t tbl[13];

   uart_tx_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_data    (req_data),
      .req_last    (req_last),
      .grant       (grant),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .busy        (busy),
      .owner       (owner),
      .locked      (locked),
      .err_timeout (err_timeout),
      .err_count   (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic wait_grant(input string nm, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         if (grant != 4'b0000) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s_grant_wait actual=none required=grant", nm);
      end
   endtask

   task automatic wait_err(input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         if (err_timeout) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s_err_wait actual=none required=err_timeout", nm);
      end
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      tx_done  = 1'b0;
      req      = 4'b0000;
      req_data = 32'h0;
      req_last = 4'b0000;
      repeat (2) step();
      reset = 1'b1;
      step();
   endtask

   task automatic run_row(input vec_t v, input int r);
      bit seen;
      req      = v.req;
      req_data = v.data;
      req_last = v.last;
      wait_grant($sformatf("row%0d", r), seen);
      if (seen) begin
         chk($sformatf("row%0d_grant", r),  32'(grant),  32'(1) << v.idx);
         chk($sformatf("row%0d_owner", r),  32'(owner),  32'(v.idx));
         chk($sformatf("row%0d_lockg", r),  32'(locked), 32'(v.lock_g));
         chk($sformatf("row%0d_data", r),   32'(tx_data), 32'(v.byt));
         step();
         chk($sformatf("row%0d_start", r),  32'(tx_start), 32'(1));
         chk($sformatf("row%0d_gpulse", r), 32'(grant), 32'(0));
         repeat (v.dly - 1) step();
         tx_done = 1'b1;
         step();
         tx_done = 1'b0;
         chk($sformatf("row%0d_busy", r),   32'(busy),   32'(0));
         chk($sformatf("row%0d_lockd", r),  32'(locked), 32'(v.lock_d));
      end
   endtask

   initial begin
      bit seen;
      bit stray;

      tbl[0]  = '{4'b1111, 32'hD3C2B1A0, 4'b1111, 5, 0, 8'hA0, 1'b0, 1'b0};
      tbl[1]  = '{4'b1111, 32'hD3C2B1A0, 4'b1111, 5, 1, 8'hB1, 1'b0, 1'b0};
      tbl[2]  = '{4'b1111, 32'hD3C2B1A0, 4'b1111, 5, 2, 8'hC2, 1'b0, 1'b0};
      tbl[3]  = '{4'b1111, 32'hD3C2B1A0, 4'b1111, 5, 3, 8'hD3, 1'b0, 1'b0};
      tbl[4]  = '{4'b1111, 32'hD3C2B1A0, 4'b1111, 5, 0, 8'hA0, 1'b0, 1'b0};
      tbl[5]  = '{4'b1111, 32'hD3C2B1A0, 4'b1111, 5, 1, 8'hB1, 1'b0, 1'b0};
      tbl[6]  = '{4'b1111, 32'hD348B1A0, 4'b1011, 5, 2, 8'h48, 1'b1, 1'b1};
      tbl[7]  = '{4'b1111, 32'hD349B1A0, 4'b1011, 5, 2, 8'h49, 1'b1, 1'b1};
      tbl[8]  = '{4'b1111, 32'hD30AB1A0, 4'b1111, 5, 2, 8'h0A, 1'b0, 1'b0};
      tbl[9]  = '{4'b1111, 32'hD3C2B1A0, 4'b1111, 5, 3, 8'hD3, 1'b0, 1'b0};
      tbl[10] = '{4'b0100, 32'hD3C2B1A0, 4'b1111, 5, 2, 8'hC2, 1'b0, 1'b0};
      tbl[11] = '{4'b0011, 32'hD3C2B1A0, 4'b1111, 5, 0, 8'hA0, 1'b0, 1'b0};
      tbl[12] = '{4'b1001, 32'hD3C2B1A0, 4'b1111, 10, 3, 8'hD3, 1'b0, 1'b0};

      reset    = 1'b0;
      tx_done  = 1'b0;
      req      = 4'b0000;
      req_data = 32'h0;
      req_last = 4'b0000;
      repeat (2) step();
      chk("rst_grant",  32'(grant),       32'(0));
      chk("rst_start",  32'(tx_start),    32'(0));
      chk("rst_data",   32'(tx_data),     32'(0));
      chk("rst_busy",   32'(busy),        32'(0));
      chk("rst_owner",  32'(owner),       32'(0));
      chk("rst_locked", 32'(locked),      32'(0));
      chk("rst_err",    32'(err_timeout), 32'(0));
      chk("rst_errcnt", 32'(err_count),   32'(0));
      reset = 1'b1;
      step();

      // Single byte from requester 0
      req      = 4'b0001;
      req_data = 32'h00000041;
      req_last = 4'b0001;
      wait_grant("single", seen);
      chk("single_grant", 32'(grant), 32'(4'b0001));
      req = 4'b0000;
      step();
      chk("single_start", 32'(tx_start), 32'(1));
      chk("single_data",  32'(tx_data),  32'(8'h41));
      step();
      chk("single_start_pulse", 32'(tx_start), 32'(0));
      chk("single_busy_wait",   32'(busy),     32'(1));
      repeat (7) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk("single_busy_done",   32'(busy),   32'(0));
      chk("single_locked_done", 32'(locked), 32'(0));

      // Round robin, packet lock and mixed request patterns
      do_reset();
      for (int r = 0; r < 13; r++) begin
         run_row(tbl[r], r);
      end
      req = 4'b0000;

      // tx_done never arrives
      do_reset();
      req      = 4'b0001;
      req_data = 32'h00000055;
      req_last = 4'b0001;
      wait_grant("tmo", seen);
      req = 4'b0000;
      step();
      chk("tmo_start", 32'(tx_start), 32'(1));
      repeat (TO - 1) step();
      chk("tmo_err_early",  32'(err_timeout), 32'(0));
      chk("tmo_busy_early", 32'(busy),        32'(1));
      step();
      chk("tmo_err",    32'(err_timeout), 32'(1));
      chk("tmo_errcnt", 32'(err_count),   32'(1));
      chk("tmo_busy",   32'(busy),        32'(0));
      step();
      chk("tmo_err_pulse", 32'(err_timeout), 32'(0));
      req      = 4'b0010;
      req_data = 32'h00006600;
      req_last = 4'b0010;
      wait_grant("tmo_next", seen);
      chk("tmo_next_grant", 32'(grant),   32'(4'b0010));
      chk("tmo_next_data",  32'(tx_data), 32'(8'h66));
      req = 4'b0000;
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk("tmo_next_errcnt", 32'(err_count), 32'(1));
      chk("tmo_next_busy",   32'(busy),      32'(0));

      // 300 more timeouts: counter must stop at 255
      req_data = 32'h00000055;
      req_last = 4'b0001;
      for (int i = 0; i < 300; i++) begin
         req = 4'b0001;
         wait_grant("sat", seen);
         req = 4'b0000;
         wait_err("sat");
         if (i == 100) chk("sat_count_mid", 32'(err_count), 32'(102));
      end
      chk("sat_count_final", 32'(err_count), 32'(255));

      // Owner 1 stalls mid-packet while requester 0 waits
      do_reset();
      req      = 4'b0010;
      req_data = 32'h00007711;
      req_last = 4'b0000;
      wait_grant("stall", seen);
      chk("stall_grant",  32'(grant),  32'(4'b0010));
      chk("stall_locked", 32'(locked), 32'(1));
      req = 4'b0001;
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk("stall_idle_busy", 32'(busy), 32'(0));
      stray = 1'b0;
      for (int k = 0; k < TO - 1; k++) begin
         step();
         if (grant != 4'b0000 || err_timeout) stray = 1'b1;
      end
      chk("stall_no_grant",   32'(stray),  32'(0));
      chk("stall_still_lock", 32'(locked), 32'(1));
      step();
      chk("stall_err",    32'(err_timeout), 32'(1));
      chk("stall_unlock", 32'(locked),      32'(0));
      chk("stall_errcnt", 32'(err_count),   32'(1));
      step();
      chk("stall_grant0",    32'(grant),       32'(4'b0001));
      chk("stall_err_pulse", 32'(err_timeout), 32'(0));

      // Asynchronous reset while the byte for requester 0 is in flight
      req = 4'b0000;
      step();
      chk("arst_pre_busy",   32'(busy),   32'(1));
      chk("arst_pre_locked", 32'(locked), 32'(1));
      #3;
      reset = 1'b0;
      #1;
      chk("arst_busy",   32'(busy),        32'(0));
      chk("arst_locked", 32'(locked),      32'(0));
      chk("arst_data",   32'(tx_data),     32'(0));
      chk("arst_errcnt", 32'(err_count),   32'(0));
      chk("arst_owner",  32'(owner),       32'(0));
      chk("arst_grant",  32'(grant),       32'(0));
      chk("arst_start",  32'(tx_start),    32'(0));
      chk("arst_err",    32'(err_timeout), 32'(0));
      step();
      reset    = 1'b1;
      req      = 4'b0010;
      req_data = 32'h00002200;
      req_last = 4'b0010;
      wait_grant("arst_after", seen);
      chk("arst_after_grant", 32'(grant),   32'(4'b0010));
      chk("arst_after_data",  32'(tx_data), 32'(8'h22));
      req = 4'b0000;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Shares one UART transmitter core among N_REQ byte-producing requesters. It uses round-robin arbitration with packet locking: once granted, a requester keeps the transmitter until it sends a byte flagged last. The block sequences the core with one start pulse per byte and waits for the core's done strobe. It sits between the application-side byte sources (text/LED reporters) and the serial TX core, mirroring the receive path.

Parameters:
N_REQ, 4, number of requesters (2..8); index width IW = clog2(N_REQ)
TIMEOUT, 2047, cycles allowed for tx_done after tx_start, and for a locked owner to present its next byte (1..65535)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous active-low reset (0 = reset)
req  in  N_REQ  per-requester byte valid, level
req_data  in  8*N_REQ  byte of requester i at [8i+7:8i]
req_last  in  N_REQ  byte of requester i ends its packet
grant  out  N_REQ  one-hot, 1-cycle pulse: byte of requester i accepted
tx_start  out  1  1-cycle pulse to TX core
tx_data  out  8  byte to TX core, stable from tx_start until tx_done
tx_done  in  1  1-cycle pulse from TX core: stop bit finished
busy  out  1  high in every state except IDLE
owner  out  IW  index of current/last granted requester
locked  out  1  packet lock held by owner
err_timeout  out  1  1-cycle pulse on any timeout
err_count  out  8  saturating timeout counter

Behaviour:
- Reset (async, reset=0): state IDLE. grant=0, tx_start=0, tx_data=0, busy=0, owner=0, locked=0, err_timeout=0, err_count=0. rr_ptr=0, timer=0, last_q=0. A reset mid-byte abandons the byte; the TX core is not notified.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE, locked=0: scan req starting at rr_ptr, wrapping modulo N_REQ. Take the first set bit k. In the same cycle: grant[k]=1, latch tx_data=req_data[k], last_q=req_last[k], owner=k, locked=~req_last[k]. Next state ISSUE. If no req is set, stay in IDLE with timer=0.
- IDLE, locked=1: only req[owner] is considered; all other requests are ignored.
  - req[owner]=1: grant and latch exactly as above, timer=0, go to ISSUE.
  - req[owner]=0: timer increments. When timer == TIMEOUT-1: locked=0, rr_ptr=owner+1 (wrapping), err_timeout pulse, err_count+1 (saturates at 255), timer=0.
- ISSUE: tx_start=1 for exactly one cycle, timer=0, go to WAIT_DONE. A tx_done arriving in this cycle is ignored.
- WAIT_DONE: timer increments each cycle.
  - tx_done=1: timer=0, go to IDLE. If last_q=1, then locked=0 and rr_ptr=owner+1 (wrapping).
  - timer == TIMEOUT-1 without tx_done: err_timeout pulse, err_count+1 (saturating), locked=0, rr_ptr=owner+1, go to IDLE.
  - If tx_done and the timeout occur in the same cycle, tx_done wins and no error is raised.
- Minimum spacing between grants is 3 cycles (IDLE→ISSUE→WAIT_DONE→IDLE). There is no back-to-back grant.
- Requester contract: hold req and req_data until its grant pulse. Grant implies the byte is consumed. A requester deasserting req before grant is allowed; it is simply not served.
- rr_ptr advances only on packet end or timeout, never per byte within a packet. This is fairness per packet.
- Single-byte packet: req_last=1 on the first byte, so locked never rises.
- grant, tx_start and err_timeout are registered outputs and never high for more than 1 cycle.

Test Plan:
- Single byte: after reset, req=0001, req_data[7:0]=0x41, req_last[0]=1 → grant=0001 one cycle; next cycle tx_start=1 with tx_data=0x41. Drive tx_done 10 cycles later → busy=0, locked=0.
- Round robin: req=1111, all req_last=1, tx_done returned 5 cycles after each start → grants in order 0,1,2,3,0. tx_data matches each requester's byte.
- Packet lock: requester 2 sends 0x48,0x49,0x0A with last only on 0x0A while req=1111 is held → grants 2,2,2, then 3. No grant to 0/1/3 while locked=1.
- Done timeout: TIMEOUT=16, tx_done held low → err_timeout pulses 16 cycles after tx_start, err_count=1. The next request is granted normally. Repeat 300 times → err_count stays 255.
- Owner stall: requester 1 sends a non-last byte and then drops req, with req[0]=1 pending → after TIMEOUT cycles err_timeout fires, locked=0, then grant to requester 2 or 0 per rr_ptr=2 scan order (requester 0 if only it is requesting).
- Async reset mid-byte: pull reset low during WAIT_DONE → all outputs 0 immediately without a clock edge. After release with req=0010 → the first grant goes to requester 1.
